// File: rtl/dvp_rgb565_capture.sv
// dvp_rgb565_capture
//   Takes OV5640 DVP signals (vsync / href / 8-bit data, already in the clk
//   domain) and packs byte pairs into RGB565 pixels. Each pixel is tagged with
//   start-of-frame and end-of-line flags and written into a sync FIFO write port.
//   The block discards SKIP_FRAMES warm-up frames after leaving idle and checks
//   line and frame geometry. After a FIFO overflow it drops the rest of the frame.
//
// Ports
//   clk         in   system / pixel clock
//   rest        in   synchronous reset, active-high
//   en          in   capture enable, only acted on at frame boundaries
//   clear       in   1-cycle pulse, clears the sticky overflow flag
//   cam_vsync   in   DVP vsync (active level VS_POL)
//   cam_href    in   DVP line valid
//   cam_data    in   DVP byte
//   full        in   FIFO full
//   write       out  FIFO write strobe (registered)
//   write_data  out  {sof, eol, rgb565[15:0]} (registered)
//   frame_done  out  1-cycle pulse when a captured or dropped frame closes
//   frame_err   out  error status of the last finished frame
//   overflow    out  sticky: a pixel was ready while the FIFO was full
module dvp_rgb565_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        en,
  input  logic        clear,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full,
  output logic        write,
  output logic [17:0] write_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [PW-1:0] H_MAX  = PW'(H_ACTIVE);
  localparam logic [PW-1:0] H_LAST = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] V_MAX  = LW'(V_ACTIVE);
  localparam logic [SW-1:0] S_MAX  = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  // input stage
  logic          vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic          href_q, href_d, href_prev_q, href_prev_d;
  logic [7:0]    data_q, data_d;
  // packing / geometry
  logic [7:0]    hi_q, hi_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  // control
  state_t        state_q, state_d;
  logic          err_acc_q, err_acc_d;
  logic          sof_pend_q, sof_pend_d;
  // outputs
  logic          write_q, write_d;
  logic [17:0]   write_data_q, write_data_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;

  // combinational events
  logic vs_edge, href_rise, href_fall, pix_rdy, pix_ok, line_err;

  always_comb begin
    vs_d        = cam_vsync;
    vs_prev_d   = vs_q;
    href_d      = cam_href;
    href_prev_d = href_q;
    data_d      = cam_data;

    vs_edge   = (vs_q == VS_POL) && (vs_prev_q != VS_POL);
    href_rise = href_q & ~href_prev_q;
    href_fall = ~href_q & href_prev_q;
    // The byte on an href rise is always byte0, whatever phase was left over.
    pix_rdy   = href_q & ~href_rise & phase_q;
    // Excess pixels or lines are counted but never become write candidates.
    pix_ok    = pix_rdy && (pix_cnt_q < H_MAX) && (line_cnt_q < V_MAX);
    // phase_q still reflects the last byte of the line in the href fall cycle.
    line_err  = href_fall && ((pix_cnt_q != H_MAX) || phase_q);

    // byte packing
    hi_d    = hi_q;
    phase_d = phase_q;
    if (!href_q) begin
      phase_d = 1'b0;
    end else if (href_rise || !phase_q) begin
      hi_d    = data_q;
      phase_d = 1'b1;
    end else begin
      phase_d = 1'b0;
    end

    // geometry counters, saturating
    pix_cnt_d = pix_cnt_q;
    if (href_rise)
      pix_cnt_d = '0;
    else if (pix_rdy && (pix_cnt_q != '1))
      pix_cnt_d = pix_cnt_q + 1'b1;

    line_cnt_d = line_cnt_q;
    if (vs_edge)
      line_cnt_d = '0;
    else if (href_fall && (line_cnt_q != '1))
      line_cnt_d = line_cnt_q + 1'b1;

    // FSM defaults
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    err_acc_d    = err_acc_q;
    sof_pend_d   = sof_pend_q;
    write_d      = 1'b0;
    write_data_d = write_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    overflow_d   = clear ? 1'b0 : overflow_q;

    case (state_q)
      S_IDLE: begin
        if (vs_edge && en) begin
          if (SKIP_FRAMES == 0) begin
            state_d    = S_CAPTURE;
            err_acc_d  = 1'b0;
            sof_pend_d = 1'b1;
          end else begin
            state_d    = S_SKIP;
            skip_cnt_d = SW'(1);
          end
        end
      end

      S_SKIP: begin
        if (vs_edge) begin
          if (!en) begin
            state_d = S_IDLE;
          end else if (skip_cnt_q >= S_MAX) begin
            state_d    = S_CAPTURE;
            err_acc_d  = 1'b0;
            sof_pend_d = 1'b1;
          end else if (skip_cnt_q != '1) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
          end
        end
      end

      S_CAPTURE: begin
        if (vs_edge) begin
          // The boundary closes the current frame and opens the next one.
          frame_done_d = 1'b1;
          frame_err_d  = err_acc_q | line_err | (line_cnt_q != V_MAX);
          err_acc_d    = 1'b0;
          sof_pend_d   = 1'b1;
          state_d      = en ? S_CAPTURE : S_IDLE;
        end else begin
          if (line_err)
            err_acc_d = 1'b1;
          if (pix_ok) begin
            if (full) begin
              // This pixel is lost, and the rest of the frame is abandoned.
              overflow_d = 1'b1;
              err_acc_d  = 1'b1;
              state_d    = S_DROP;
            end else begin
              write_d      = 1'b1;
              write_data_d = {sof_pend_q, (pix_cnt_q == H_LAST), hi_q, data_q};
              sof_pend_d   = 1'b0;
            end
          end
        end
      end

      S_DROP: begin
        if (vs_edge) begin
          frame_done_d = 1'b1;
          frame_err_d  = 1'b1;
          err_acc_d    = 1'b0;
          sof_pend_d   = 1'b1;
          state_d      = en ? S_CAPTURE : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= '0;
      hi_q         <= '0;
      phase_q      <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      skip_cnt_q   <= '0;
      state_q      <= S_IDLE;
      err_acc_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      write_q      <= 1'b0;
      write_data_q <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      href_q       <= href_d;
      href_prev_q  <= href_prev_d;
      data_q       <= data_d;
      hi_q         <= hi_d;
      phase_q      <= phase_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      state_q      <= state_d;
      err_acc_q    <= err_acc_d;
      sof_pend_q   <= sof_pend_d;
      write_q      <= write_d;
      write_data_q <= write_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign write      = write_q;
  assign write_data = write_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// tb_dvp_rgb565_capture
//   Drives DVP frames into dvp_rgb565_capture (H=4, V=2, one skip frame).
//   Expected pixels are queued together with the cycle in which they must
//   appear, and they are compared in the order the DUT writes them.
module tb_dvp_rgb565_capture;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 1;

  logic        clk = 1'b0;
  logic        rest, en, clear, cam_vsync, cam_href, full;
  logic [7:0]  cam_data;
  logic        write, frame_done, frame_err, overflow;
  logic [17:0] write_data;

  dvp_rgb565_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK), .VS_POL(1'b1)
  ) u_dut (
    .clk(clk), .rest(rest), .en(en), .clear(clear),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .full(full), .write(write), .write_data(write_data),
    .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // scoreboard
  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [17:0] obs_log[$];
  int          wr_cnt  = 0;
  int          fd_cnt  = 0;
  logic        fd_err  = 1'b0;
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    if (write) begin
      wr_cnt <= wr_cnt + 1;
      obs_log.push_back(write_data);
      chk("wr_while_full", full, 0);
      chk("wr_back_to_back", prev_wr, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 1, 0);
      end else begin
        chk("wr_data", write_data, exp_q.pop_front());
        chk("wr_latency_cyc", cyc, exp_cyc_q.pop_front());
      end
    end
    prev_wr <= write;
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_err <= frame_err;
    end
  end

  // frame model state
  logic [7:0] bval, hi;
  int         f_line, f_pix;
  bit         f_sof, f_drop, full_pend;

  task automatic drv(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk); #1;
    cam_vsync = vs; cam_href = hr; cam_data = d; full = full_pend;
  endtask

  // Blank gap, vsync pulse, blank gap; afterwards the model starts a new frame.
  task automatic vs_pulse();
    full_pend = 1'b0;
    repeat (3) drv(1'b0, 1'b0, 8'h00);
    repeat (3) drv(1'b1, 1'b0, 8'h00);
    repeat (3) drv(1'b0, 1'b0, 8'h00);
    chk("sb_drained", exp_q.size(), 0);
    f_line = 0; f_pix = 0; f_sof = 1'b1; f_drop = 1'b0; bval = 8'h12;
  endtask

  // nl lines of nb bytes. cp: the DUT is expected to be capturing.
  // full goes high right after the pixel with frame index full_at (-1 = never).
  task automatic lines(input int nl, input int nb, input int full_at, input bit cp);
    for (int l = 0; l < nl; l++) begin
      repeat (3) drv(1'b0, 1'b0, 8'h00);
      for (int b = 0; b < nb; b++) begin
        drv(1'b0, 1'b1, bval);
        if ((b % 2) == 0) begin
          hi = bval;
        end else begin
          if (cp && !f_drop && (b / 2 < H) && (f_line < V)) begin
            if (f_pix == full_at) begin
              f_drop    = 1'b1;
              full_pend = 1'b1;
            end else begin
              exp_q.push_back({f_sof, (b / 2 == H - 1), hi, bval});
              exp_cyc_q.push_back(cyc + 2);
              f_sof = 1'b0;
            end
          end
          f_pix++;
        end
        bval = bval + 8'h22;
      end
      f_line++;
    end
  endtask

  int w0;

  initial begin
    rest = 1'b1; en = 1'b0; clear = 1'b0; full = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    full_pend = 1'b0; bval = 8'h12; hi = 8'h00;
    f_line = 0; f_pix = 0; f_sof = 1'b1; f_drop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1; rest = 1'b0;

    // clean frames: the first one is skipped, the second one is captured
    en = 1'b1;
    vs_pulse();
    w0 = wr_cnt;
    lines(2, 8, -1, 1'b0);
    vs_pulse();
    chk("t1_skip_wr", wr_cnt - w0, 0);
    chk("t1_skip_fd", fd_cnt, 0);
    obs_log.delete();
    w0 = wr_cnt;
    lines(2, 8, -1, 1'b1);
    vs_pulse();
    chk("t1_wr_cnt", wr_cnt - w0, 8);
    chk("t1_log_size", obs_log.size(), 8);
    if (obs_log.size() >= 4) begin
      chk("t1_first_sof", obs_log[0], 18'h21234);
      chk("t1_4th_eol", obs_log[3][16], 1);
    end
    chk("t1_fd_cnt", fd_cnt, 1);
    chk("t1_fd_err", fd_err, 0);

    // overflow on the third pixel drops the frame
    w0 = wr_cnt;
    lines(2, 8, 2, 1'b1);
    @(negedge clk);
    chk("t3_overflow_set", overflow, 1);
    vs_pulse();
    chk("t3_wr_cnt", wr_cnt - w0, 2);
    chk("t3_fd_cnt", fd_cnt, 2);
    chk("t3_fd_err", fd_err, 1);
    w0 = wr_cnt;
    lines(2, 8, -1, 1'b1);
    vs_pulse();
    chk("t3_next_wr_cnt", wr_cnt - w0, 8);
    chk("t3_next_fd_cnt", fd_cnt, 3);
    chk("t3_next_fd_err", fd_err, 0);
    chk("t3_overflow_sticky", overflow, 1);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    chk("t3_overflow_clear", overflow, 0);

    // geometry errors: 5-pixel lines, 7-byte lines, 3-line frame
    w0 = wr_cnt;
    lines(2, 10, -1, 1'b1);
    vs_pulse();
    chk("t4_long_wr", wr_cnt - w0, 8);
    chk("t4_long_fd", fd_cnt, 4);
    chk("t4_long_err", fd_err, 1);
    w0 = wr_cnt;
    lines(2, 7, -1, 1'b1);
    vs_pulse();
    chk("t4_odd_wr", wr_cnt - w0, 6);
    chk("t4_odd_fd", fd_cnt, 5);
    chk("t4_odd_err", fd_err, 1);
    w0 = wr_cnt;
    lines(3, 8, -1, 1'b1);
    vs_pulse();
    chk("t4_lines_wr", wr_cnt - w0, 8);
    chk("t4_lines_fd", fd_cnt, 6);
    chk("t4_lines_err", fd_err, 1);

    // en drops mid-frame: the frame completes, then the DUT goes idle
    w0 = wr_cnt;
    lines(1, 8, -1, 1'b1);
    en = 1'b0;
    lines(1, 8, -1, 1'b1);
    vs_pulse();
    chk("t5_wr_cnt", wr_cnt - w0, 8);
    chk("t5_fd_cnt", fd_cnt, 7);
    chk("t5_fd_err", fd_err, 0);
    w0 = wr_cnt;
    lines(2, 8, -1, 1'b0);
    vs_pulse();
    chk("t5_idle_wr", wr_cnt - w0, 0);
    chk("t5_idle_fd", fd_cnt, 7);

    // reset mid-line, then the skip frame must happen again
    en = 1'b1;
    vs_pulse();
    lines(2, 8, -1, 1'b0);
    vs_pulse();
    lines(1, 5, -1, 1'b1);
    @(posedge clk); #1; rest = 1'b1; cam_href = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_write", write, 0);
    chk("t6_rst_write_data", write_data, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_frame_done", frame_done, 0);
    chk("t6_sb_drained", exp_q.size(), 0);
    @(posedge clk); #1; rest = 1'b0;
    vs_pulse();
    w0 = wr_cnt;
    lines(2, 8, -1, 1'b0);
    vs_pulse();
    chk("t6_reskip_wr", wr_cnt - w0, 0);
    chk("t6_reskip_fd", fd_cnt, 7);
    w0 = wr_cnt;
    lines(2, 8, -1, 1'b1);
    vs_pulse();
    chk("t6_cap_wr", wr_cnt - w0, 8);
    chk("t6_cap_fd", fd_cnt, 8);
    chk("t6_cap_err", fd_err, 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    $display("FAIL watchdog: run still active at time %0t, want finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
